// File: rtl/text_display_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : text_display_sequencer
//  Purpose  : Steps through NUM_MSG text slots, driving an external display
//             timer per slot, with skip, abort, looping and pass counting.
//  Revision : 1.0  initial release
// ============================================================================
module text_display_sequencer #(
    parameter int NUM_MSG = 4,
    parameter int IDX_W   = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             stop,
    input  logic             skip,
    input  logic             loop_mode,
    input  logic             timer_done,
    output logic             timer_enable,
    output logic             timer_clear,
    output logic             display_on,
    output logic [IDX_W-1:0] msg_index,
    output logic             busy,
    output logic             seq_done,
    output logic [7:0]       pass_count
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_SHOW = 3'd2,
        S_NEXT = 3'd3,
        S_DONE = 3'd4
    } state_t;

    localparam logic [IDX_W-1:0] C_LAST_IDX = IDX_W'(NUM_MSG - 1);
    localparam logic [IDX_W-1:0] C_IDX_ONE  = IDX_W'(1);

    state_t           r_state;
    state_t           w_state_next;
    logic [IDX_W-1:0] r_msg_index;
    logic [IDX_W-1:0] w_msg_index_next;
    logic [7:0]       r_pass_count;
    logic [7:0]       w_pass_count_next;

    // State, slot index and pass counter registers; reset acts immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_msg_index  <= '0;
            r_pass_count <= 8'd0;
        end else begin
            r_state      <= w_state_next;
            r_msg_index  <= w_msg_index_next;
            r_pass_count <= w_pass_count_next;
        end
    end

    // Next-state, next-index and pass-count update; stop aborts any active phase.
    always_comb begin
        w_state_next      = r_state;
        w_msg_index_next  = r_msg_index;
        w_pass_count_next = r_pass_count;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_next     = S_LOAD;
                    w_msg_index_next = '0;
                end
            end
            S_LOAD: begin
                if (stop) begin
                    w_state_next     = S_IDLE;
                    w_msg_index_next = '0;
                end else begin
                    w_state_next = S_SHOW;
                end
            end
            S_SHOW: begin
                if (stop) begin
                    w_state_next     = S_IDLE;
                    w_msg_index_next = '0;
                end else if (timer_done || skip) begin
                    // Simultaneous skip and expiry collapse into a single advance.
                    w_state_next = S_NEXT;
                end
            end
            S_NEXT: begin
                if (stop) begin
                    w_state_next     = S_IDLE;
                    w_msg_index_next = '0;
                end else if (r_msg_index != C_LAST_IDX) begin
                    w_state_next     = S_LOAD;
                    w_msg_index_next = r_msg_index + C_IDX_ONE;
                end else begin
                    // Last slot finished: a full pass is complete (8-bit wrap is intended).
                    w_pass_count_next = r_pass_count + 8'd1;
                    if (loop_mode) begin
                        w_state_next     = S_LOAD;
                        w_msg_index_next = '0;
                    end else begin
                        w_state_next = S_DONE;
                    end
                end
            end
            S_DONE: begin
                w_state_next     = S_IDLE;
                w_msg_index_next = '0;
            end
            default: begin
                w_state_next     = S_IDLE;
                w_msg_index_next = '0;
            end
        endcase
    end

    // Moore output decode from the registered state only.
    always_comb begin
        timer_clear  = (r_state == S_LOAD);
        timer_enable = (r_state == S_SHOW);
        display_on   = (r_state == S_LOAD) || (r_state == S_SHOW) || (r_state == S_NEXT);
        seq_done     = (r_state == S_DONE);
        busy         = (r_state != S_IDLE);
    end

    assign msg_index  = r_msg_index;
    assign pass_count = r_pass_count;

endmodule
`default_nettype wire

// File: tb/tb_text_display_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_text_display_sequencer
//  Purpose  : Self-checking bench for text_display_sequencer (NUM_MSG=4).
//  Revision : 1.0  initial release
// ============================================================================
module tb_text_display_sequencer;

    localparam int NUM_MSG = 4;
    localparam int IDX_W   = 2;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             start = 1'b0, stop = 1'b0, skip = 1'b0;
    logic             loop_mode = 1'b0, timer_done = 1'b0;
    logic             timer_enable, timer_clear, display_on, busy, seq_done;
    logic [IDX_W-1:0] msg_index;
    logic [7:0]       pass_count;

    int checks = 0;
    int errors = 0;

    text_display_sequencer #(.NUM_MSG(NUM_MSG), .IDX_W(IDX_W)) dut (
        .clk(clk), .reset(reset), .start(start), .stop(stop), .skip(skip),
        .loop_mode(loop_mode), .timer_done(timer_done),
        .timer_enable(timer_enable), .timer_clear(timer_clear),
        .display_on(display_on), .msg_index(msg_index), .busy(busy),
        .seq_done(seq_done), .pass_count(pass_count)
    );

    always #5 clk = ~clk;

    // Reference model: "is a sequence running", which slot, which step of
    // that slot's show cycle, and an unbounded count of finished passes.
    bit m_active = 0;
    int m_slot   = 0;
    int m_step   = 0;   // 0 prepare, 1 showing, 2 advancing, 3 finishing
    int m_passes = 0;

    task automatic model_edge(input logic st, sp, sk, lm, td, rs);
        if (rs) begin
            m_active = 0; m_slot = 0; m_passes = 0;
        end else if (!m_active) begin
            if (st) begin m_active = 1; m_slot = 0; m_step = 0; end
        end else if (m_step == 3) begin
            m_active = 0; m_slot = 0;
        end else if (sp) begin
            m_active = 0; m_slot = 0;
        end else if (m_step == 0) begin
            m_step = 1;
        end else if (m_step == 1) begin
            if (td || sk) m_step = 2;
        end else begin
            if (m_slot == NUM_MSG - 1) begin
                m_passes++;
                m_slot = 0;
                m_step = lm ? 0 : 3;
            end else begin
                m_slot++;
                m_step = 0;
            end
        end
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_model();
        chk("m_busy", int'(busy), int'(m_active));
        chk("m_clear", int'(timer_clear), int'(m_active && m_step == 0));
        chk("m_enable", int'(timer_enable), int'(m_active && m_step == 1));
        chk("m_display", int'(display_on), int'(m_active && m_step < 3));
        chk("m_done", int'(seq_done), int'(m_active && m_step == 3));
        chk("m_index", int'(msg_index), (m_active && m_step == 3) ? NUM_MSG - 1 : m_slot);
        chk("m_passes", int'(pass_count), m_passes % 256);
    endtask

    // One clock: drive inputs at the falling edge, update the model after the
    // rising edge, leave outputs to be sampled 4ns later.
    task automatic step(input logic st, sp, sk, lm, td, rs);
        @(negedge clk);
        start = st; stop = sp; skip = sk; loop_mode = lm; timer_done = td; reset = rs;
        @(posedge clk);
        #1;
        model_edge(st, sp, sk, lm, td, rs);
        #3;
    endtask

    typedef struct packed {
        logic st, sp, sk, td;
        logic busy, clr, en, disp, done;
        logic [1:0] idx;
        logic [7:0] pc;
    } vec_t;

    vec_t tbl [25];
    bit   saw_done;

    initial begin
        //          st   sp   sk   td   busy clr  en   disp done idx  pc
        tbl[0]  = '{1'b1,1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,1'b1,1'b0,2'd0,8'd0}; // LOAD 0
        tbl[1]  = '{1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,1'b1,1'b0,2'd0,8'd0}; // SHOW 0
        tbl[2]  = '{1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,1'b1,1'b0,2'd0,8'd0}; // NEXT 0
        tbl[3]  = '{1'b1,1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,1'b1,1'b0,2'd1,8'd0}; // LOAD 1, start ignored
        tbl[4]  = '{1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,1'b1,1'b0,2'd1,8'd0}; // SHOW 1
        tbl[5]  = '{1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b1,1'b0,2'd1,8'd0}; // skip -> NEXT 1
        tbl[6]  = '{1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,1'b1,1'b0,2'd2,8'd0}; // LOAD 2
        tbl[7]  = '{1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,1'b1,1'b0,2'd2,8'd0}; // SHOW 2
        tbl[8]  = '{1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'd0,8'd0}; // stop wins -> IDLE
        tbl[9]  = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'd0,8'd0}; // stays IDLE
        tbl[10] = '{1'b1,1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,1'b1,1'b0,2'd0,8'd0}; // LOAD 0
        tbl[11] = '{1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,1'b1,1'b0,2'd0,8'd0}; // SHOW 0
        tbl[12] = '{1'b0,1'b0,1'b1,1'b1,1'b1,1'b0,1'b0,1'b1,1'b0,2'd0,8'd0}; // skip+timer -> NEXT 0
        tbl[13] = '{1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,1'b1,1'b0,2'd1,8'd0}; // single advance
        tbl[14] = '{1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,1'b1,1'b0,2'd1,8'd0};
        tbl[15] = '{1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,1'b1,1'b0,2'd1,8'd0};
        tbl[16] = '{1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,1'b1,1'b0,2'd2,8'd0};
        tbl[17] = '{1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,1'b1,1'b0,2'd2,8'd0};
        tbl[18] = '{1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,1'b1,1'b0,2'd2,8'd0};
        tbl[19] = '{1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,1'b1,1'b0,2'd3,8'd0};
        tbl[20] = '{1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,1'b1,1'b0,2'd3,8'd0};
        tbl[21] = '{1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,1'b1,1'b0,2'd3,8'd0}; // NEXT 3
        tbl[22] = '{1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b1,2'd3,8'd1}; // DONE pulse
        tbl[23] = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'd0,8'd1}; // IDLE
        tbl[24] = '{1'b0,1'b1,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'd0,8'd1}; // ignored in IDLE

        // Reset state
        #7;
        chk("rst_busy", int'(busy), 0);
        chk("rst_display", int'(display_on), 0);
        chk("rst_index", int'(msg_index), 0);
        chk("rst_passes", int'(pass_count), 0);
        step(0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0);
        chk_model();

        // Directed table
        for (int i = 0; i < 25; i++) begin
            step(tbl[i].st, tbl[i].sp, tbl[i].sk, 1'b0, tbl[i].td, 1'b0);
            chk($sformatf("t%0d_busy", i), int'(busy), int'(tbl[i].busy));
            chk($sformatf("t%0d_clear", i), int'(timer_clear), int'(tbl[i].clr));
            chk($sformatf("t%0d_enable", i), int'(timer_enable), int'(tbl[i].en));
            chk($sformatf("t%0d_display", i), int'(display_on), int'(tbl[i].disp));
            chk($sformatf("t%0d_done", i), int'(seq_done), int'(tbl[i].done));
            chk($sformatf("t%0d_index", i), int'(msg_index), int'(tbl[i].idx));
            chk($sformatf("t%0d_passes", i), int'(pass_count), int'(tbl[i].pc));
        end

        // Asynchronous reset between edges while showing slot 0
        step(1, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        chk("ar_pre_enable", int'(timer_enable), 1);
        #2 reset = 1'b1;
        #1;
        chk("ar_busy", int'(busy), 0);
        chk("ar_enable", int'(timer_enable), 0);
        chk("ar_display", int'(display_on), 0);
        chk("ar_index", int'(msg_index), 0);
        chk("ar_passes", int'(pass_count), 0);
        step(0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0);
        chk("ar_wait_idle", int'(busy), 0);
        step(1, 0, 0, 0, 0, 0);
        chk("ar_restart_clear", int'(timer_clear), 1);
        chk("ar_restart_index", int'(msg_index), 0);

        // Looping with instant expiry: 256+ passes, pass counter wraps, never done
        saw_done = 0;
        step(0, 0, 0, 0, 0, 1);
        step(1, 0, 0, 1, 1, 0);
        for (int c = 0; c < 256 * 12 + 40 && m_passes < 258; c++) begin
            step(0, 0, 0, 1, 1, 0);
            if (seq_done) saw_done = 1;
            chk_model();
            if (m_passes == 256 && m_step == 0 && m_slot == 0) begin
                chk("wrap_passes", int'(pass_count), 0);
                chk("wrap_busy", int'(busy), 1);
            end
        end
        chk("wrap_reached", m_passes, 258);
        chk("loop_no_done", int'(saw_done), 0);
        chk("wrap_final", int'(pass_count), 2);

        // Randomised traffic checked against the model
        step(0, 0, 0, 0, 0, 1);
        for (int c = 0; c < 3000; c++) begin
            step(($urandom % 4) == 0, ($urandom % 25) == 0, ($urandom % 8) == 0,
                 ($urandom % 3) == 0, ($urandom % 4) == 0, ($urandom % 300) == 0);
            chk_model();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
